ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
//  Consumes op1/op2/inst fields registered by the ID->EX pipeline register.
//  On start it latches its operands. While it iterates, it raises a hold request
//  that ctrl turns into a pipeline stall, so NOP bubbles upstream are harmless.
//  When done, it presents the result and rd address for one cycle to the EX writeback mux.
// PARAMETERS
//  DATA_W   32   operand/result width; iteration count = DATA_W
// PORTS
//  clk_i         in   1       clock; one clock domain
//  rst_n_i       in   1       reset; asynchronous, active-low
//  start_i       in   1       EX decoded an M-ext divide op this cycle
//  funct3_i      in   3       3'b100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op1_i         in   DATA_W  dividend (rs1)
//  op2_i         in   DATA_W  divisor (rs2)
//  reg_waddr_i   in   5       rd of the divide instruction
//  flush_i       in   1       jump/trap flush from ctrl; aborts operation
//  result_o      out  DATA_W  quotient or remainder; valid when ready_o
//  ready_o       out  1       one-cycle pulse: result_o/reg_waddr_o valid, write rd
//  reg_waddr_o   out  5       latched rd
//  busy_o        out  1       state != IDLE
//  hold_req_o    out  1       stall request to ctrl (combinational)
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): state=IDLE; result_o=0, ready_o=0, reg_waddr_o=0,
//    busy_o=0, hold_req_o=0, all internal regs=0.
//  - FSM states: IDLE, CALC, DONE.
//  - IDLE, start_i=1, funct3_i[2]=1, flush_i=0: latch the operands, op, and rd.
//    - If op2_i==0, go to DONE.
//    - Otherwise go to CALC with count=0.
//  - IDLE, start_i with funct3_i[2]=0: ignored.
//  - CALC: one restoring shift-subtract step per cycle on magnitudes.
//    - count increments; at count==DATA_W-1, go to DONE.
//  - DONE: ready_o=1 for exactly one cycle, then IDLE.
//    - A start_i in the DONE cycle is ignored; a new divide is accepted from IDLE.
//  - Latency (start cycle = 0):
//    - nonzero divisor: ready_o at cycle DATA_W+1 (33).
//    - zero divisor: ready_o at cycle 1.
//  - hold_req_o = (IDLE & start_i & funct3_i[2] & ~flush_i) | CALC.
//    - It is low in DONE so the pipeline advances with the writeback.
//  - Signed ops: divide |op1| by |op2|.
//    - Quotient is negated iff the operand signs differ.
//    - Remainder takes the sign of the dividend.
//  - Divide by zero:
//    - quotient = all ones (-1 for DIV, 2^DATA_W-1 for DIVU).
//    - remainder = dividend unchanged.
//  - Signed overflow (-2^31 / -1): quotient = 0x8000_0000, remainder = 0.
//    - This falls out of the magnitude path naturally; no special case is needed.
//  - Result select: funct3[1]=0 gives the quotient, funct3[1]=1 gives the remainder.
//  - result_o and reg_waddr_o hold their last value outside DONE; only ready_o qualifies them.
//  - flush_i in CALC or DONE: next state IDLE, ready_o=0 that cycle, no writeback.
//    - flush_i in IDLE blocks start.
//    - flush_i has priority over start_i and over DONE.
//  - Operands are never re-sampled after start; input changes during CALC are ignored.
// STRUCTURE
//  - Shared defines: DIV/DIVU/REM/REMU funct3 codes and the M-ext funct7 constant
//    (7'b0000001) go in defines.v; the FSM state typedef goes in the shared package.
//  - Single module; no sub-module. The datapath is one DATA_W-wide subtractor,
//    a 2*DATA_W remainder/quotient shift register, and a $clog2(DATA_W) counter.
//  - Sign fix-up is combinational on the DONE outputs.
// TESTING
//  1. DIVU 100/7: ready_o exactly 33 cycles after start; result 14 (REMU gives 2);
//     hold_req_o high for cycles 0..32, low at 33.
//  2. DIV -20/3 = 0xFFFF_FFFA (-6); REM -20/3 = 0xFFFF_FFFE (-2); REM 20/-3 = 2.
//  3. DIV 5/0 = 0xFFFF_FFFF and REM 5/0 = 5, both with ready_o at cycle 1.
//  4. DIV 0x8000_0000 / 0xFFFF_FFFF = 0x8000_0000; REM of the same operands = 0.
//  5. flush_i at cycle 10 of CALC: IDLE next cycle, no ready_o, hold_req_o drops;
//     a new DIVU 9/3 afterwards returns 3.
//  6. Assert rst_n_i at cycle 5 of CALC: outputs 0 immediately, without a clock edge;
//     after release a fresh op completes normally. Changing op1_i during CALC
//     does not change the result.

Source files
------------

// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared divider types and RV32M divide encodings
package ex_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [2:0] F3_DIV        = 3'b100;
  localparam logic [2:0] F3_DIVU       = 3'b101;
  localparam logic [2:0] F3_REM        = 3'b110;
  localparam logic [2:0] F3_REMU       = 3'b111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [4:0]        reg_waddr_o,
  output logic              busy_o,
  output logic              hold_req_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] quot_q, rem_q, divisor_q, result_q;
  logic              neg_quot_q, neg_rem_q, sel_rem_q;
  logic [4:0]        reg_waddr_q;

  logic              start_ok;
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_mag, op2_mag;
  logic [DATA_W:0]   shift_val, diff;
  logic [DATA_W-1:0] quot_d, rem_d;
  logic [DATA_W-1:0] result_fix;

  assign start_ok = (state_q == ST_IDLE) & start_i & funct3_i[2] & ~flush_i;

  // funct3[0]==0 marks the signed variants; magnitudes feed the unsigned core
  assign op1_neg = ~funct3_i[0] & op1_i[DATA_W-1];
  assign op2_neg = ~funct3_i[0] & op2_i[DATA_W-1];
  assign op1_mag = op1_neg ? -op1_i : op1_i;
  assign op2_mag = op2_neg ? -op2_i : op2_i;

  // quot_q starts as the dividend and shifts its bits out into the partial remainder
  assign shift_val = {rem_q, quot_q[DATA_W-1]};
  assign diff      = shift_val - {1'b0, divisor_q};
  assign rem_d     = diff[DATA_W] ? shift_val[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quot_d    = {quot_q[DATA_W-2:0], ~diff[DATA_W]};

  assign result_fix = sel_rem_q ? (neg_rem_q  ? -rem_q  : rem_q)
                                : (neg_quot_q ? -quot_q : quot_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      result_q    <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      sel_rem_q   <= 1'b0;
      reg_waddr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            reg_waddr_q <= reg_waddr_i;
            sel_rem_q   <= funct3_i[1];
            count_q     <= '0;
            if (op2_i == '0) begin
              // divide by zero: quotient all ones, remainder is the raw dividend
              quot_q     <= '1;
              rem_q      <= op1_i;
              divisor_q  <= '0;
              neg_quot_q <= 1'b0;
              neg_rem_q  <= 1'b0;
              state_q    <= ST_DONE;
            end else begin
              quot_q     <= op1_mag;
              rem_q      <= '0;
              divisor_q  <= op2_mag;
              neg_quot_q <= op1_neg ^ op2_neg;
              neg_rem_q  <= op1_neg;
              state_q    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            count_q <= count_q + 1'b1;
            if (count_q == CNT_LAST) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (!flush_i) result_q <= result_fix;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_o    = (state_q == ST_DONE) ? result_fix : result_q;
  assign ready_o     = (state_q == ST_DONE) & ~flush_i;
  assign reg_waddr_o = reg_waddr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign hold_req_o  = start_ok | (state_q == ST_CALC);

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - scoreboard bench for the ex_div divider
module tb_ex_div;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;
  logic        hold_req_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  ex_div #(.DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start_i),
    .funct3_i    (funct3_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .reg_waddr_o (reg_waddr_o),
    .busy_o      (busy_o),
    .hold_req_o  (hold_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F3_DIV:  model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      F3_DIVU: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv);
    exp_t e;
    @(negedge clk);
    start_i     = 1'b1;
    funct3_i    = f3;
    op1_i       = a;
    op2_i       = b;
    reg_waddr_i = rd;
    e.res = expv;
    e.rd  = rd;
    e.lat = (b == 0) ? 1 : 33;
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      #1;
      if (ready_o === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 0; funct3_i = 0; op1_i = 0; op2_i = 0; reg_waddr_i = 0; flush_i = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({result_o, ready_o, reg_waddr_o, busy_o, hold_req_o} !== 40'h0) begin
      bad++;
      $display("FAIL reset_outputs: got res=%h rdy=%b rd=%0d busy=%b hold=%b want all zero",
               result_o, ready_o, reg_waddr_o, busy_o, hold_req_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_latency;
    exp_t e;
    int cyc;
    logic hold_ok;
    issue(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
    #1;
    hold_ok = (hold_req_o === 1'b1);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
      #1;
      if (ready_o === 1'b1) begin
        cyc = c;
        if (hold_req_o !== 1'b0) hold_ok = 1'b0;
        break;
      end else if (hold_req_o !== 1'b1) begin
        hold_ok = 1'b0;
      end
    end
    e = sb_q.pop_front();
    total++;
    if (cyc != e.lat) begin bad++; $display("FAIL divu_latency: got %0d want %0d", cyc, e.lat); end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL divu_hold: got irregular hold_req want high 0..32 low 33"); end
    total++;
    if (result_o !== e.res) begin bad++; $display("FAIL divu_result: got %h want %h", result_o, e.res); end
    total++;
    if (reg_waddr_o !== e.rd) begin bad++; $display("FAIL divu_rd: got %0d want %0d", reg_waddr_o, e.rd); end

    issue(F3_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (cyc != e.lat || result_o !== e.res) begin
      bad++; $display("FAIL remu_result: got %h at %0d want %h at %0d", result_o, cyc, e.res, e.lat);
    end
  endtask

  task automatic test_signed;
    exp_t e;
    int cyc;
    logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_REM};
    logic [31:0] as  [3] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20};
    logic [31:0] bs  [3] = '{32'd3, 32'd3, 32'hFFFF_FFFD};
    logic [31:0] xs  [3] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2};
    for (int i = 0; i < 3; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(10 + i), xs[i]);
      wait_ready(cyc);
      e = sb_q.pop_front();
      total++;
      if (cyc != e.lat || result_o !== e.res || reg_waddr_o !== e.rd) begin
        bad++;
        $display("FAIL signed_%0d: got %h rd=%0d at %0d want %h rd=%0d at %0d",
                 i, result_o, reg_waddr_o, cyc, e.res, e.rd, e.lat);
      end
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int cyc;
    issue(F3_DIV, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (cyc != 1 || result_o !== e.res) begin
      bad++; $display("FAIL div_zero_q: got %h at %0d want %h at 1", result_o, cyc, e.res);
    end
    issue(F3_REM, 32'd5, 32'd0, 5'd4, 32'd5);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (cyc != 1 || result_o !== e.res) begin
      bad++; $display("FAIL div_zero_r: got %h at %0d want %h at 1", result_o, cyc, e.res);
    end
  endtask

  task automatic test_overflow;
    exp_t e;
    int cyc;
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (result_o !== e.res) begin bad++; $display("FAIL ovf_div: got %h want %h", result_o, e.res); end
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (result_o !== e.res) begin bad++; $display("FAIL ovf_rem: got %h want %h", result_o, e.res); end
  endtask

  task automatic test_done_start;
    exp_t e;
    int cyc;
    issue(F3_DIVU, 32'd50, 32'd5, 5'd12, 32'd10);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (result_o !== e.res) begin bad++; $display("FAIL done_start_res: got %h want %h", result_o, e.res); end
    start_i = 1'b1; funct3_i = F3_DIVU; op1_i = 32'd7; op2_i = 32'd1;
    #1;
    total++;
    if (hold_req_o !== 1'b0) begin bad++; $display("FAIL done_hold: got %b want 0", hold_req_o); end
    @(negedge clk);
    start_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++; $display("FAIL done_start_ignored: got busy=%b rdy=%b want 0 0", busy_o, ready_o);
    end
  endtask

  task automatic test_flush;
    exp_t e;
    int cyc;
    logic seen;
    issue(F3_DIVU, 32'd100, 32'd7, 5'd20, 32'd14);
    e = sb_q.pop_back();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || hold_req_o !== 1'b0) begin
      bad++; $display("FAIL flush_idle: got busy=%b hold=%b want 0 0", busy_o, hold_req_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL flush_no_ready: got ready pulse want none"); end
    issue(F3_DIVU, 32'd9, 32'd3, 5'd21, 32'd3);
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (cyc != e.lat || result_o !== e.res || reg_waddr_o !== e.rd) begin
      bad++; $display("FAIL flush_after: got %h rd=%0d at %0d want %h rd=%0d at %0d",
                      result_o, reg_waddr_o, cyc, e.res, e.rd, e.lat);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    int cyc;
    issue(F3_DIV, 32'd1000, 32'hFFFF_FFF9, 5'd17, 32'hFFFF_FF72);
    e = sb_q.pop_back();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start_i = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({result_o, ready_o, reg_waddr_o, busy_o, hold_req_o} !== 40'h0) begin
      bad++;
      $display("FAIL async_reset: got res=%h rdy=%b rd=%0d busy=%b hold=%b want all zero",
               result_o, ready_o, reg_waddr_o, busy_o, hold_req_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(F3_DIVU, 32'd1000, 32'd7, 5'd9, 32'd142);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    op1_i = 32'd5;
    op2_i = 32'd1;
    wait_ready(cyc);
    e = sb_q.pop_front();
    total++;
    if (cyc < 0 || result_o !== e.res || reg_waddr_o !== e.rd) begin
      bad++; $display("FAIL operand_change: got %h rd=%0d want %h rd=%0d", result_o, reg_waddr_o, e.res, e.rd);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc;
    logic [2:0]  f3;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      a  = $urandom;
      case (i % 4)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 50));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        default: b = $urandom;
      endcase
      if (i == 5) a = 32'h8000_0000;
      issue(f3, a, b, 5'($urandom_range(0, 31)), model(f3, a, b));
      wait_ready(cyc);
      e = sb_q.pop_front();
      total++;
      if (cyc != e.lat || result_o !== e.res || reg_waddr_o !== e.rd) begin
        bad++;
        $display("FAIL b2b_%0d f3=%b a=%h b=%h: got %h rd=%0d at %0d want %h rd=%0d at %0d",
                 i, f3, a, b, result_o, reg_waddr_o, cyc, e.res, e.rd, e.lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_divu_latency;
    test_signed;
    test_div_zero;
    test_overflow;
    test_done_start;
    test_flush;
    test_async_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
